instr_buffer_fill_ctrl: RTL
===========================

// Module: instr_buffer_fill_ctrl
// PURPOSE
//  Circular instruction buffer: accepts fetched words on a valid/ready handshake and stores them in bs slots.
//  Issues words oldest-first to the decode consumer.
//  Drives the downstream buffer-validator port (buffer_index / Instr_in) every cycle, so the per-slot valid bits
//  always equal |mem[slot]. Sits between fetch and the validator/issue stage.
// PARAMETERS
//  Instruction_word_size  32  width of one instruction word
//  bs                     16  slot count; power of two, >= 2
// PORTS
//  clk           in   1        clock; single clock domain
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        fetch offers in_instr
//  in_instr      in   IWS      fetched instruction word
//  in_ready      out  1        buffer accepts this cycle
//  rd_en         in   1        consumer pops head slot
//  rd_instr      out  IWS      head word, mem[rd_ptr]
//  rd_valid      out  1        head is meaningful
//  flush         in   1        discard all contents
//  buffer_index  out  IDX_W    slot index presented to validator
//  Instr_in      out  IWS      word presented to validator for that slot
//  count         out  IDX_W+1  occupied slots
//  full / empty  out  1        count==bs / count==0
// BEHAVIOUR
//  FSM: SWEEP, RUN.
//  - SWEEP: sweep_cnt steps 0..bs-1, one slot per cycle; mem[sweep_cnt]<=0; buffer_index=sweep_cnt, Instr_in=0.
//    in_ready=0, rd_valid=0. After slot bs-1 -> RUN. Takes exactly bs cycles.
//  - rst or flush (any state): wr_ptr=rd_ptr=count=0, sweep_cnt=0, enter SWEEP next cycle. Same-cycle push/pop dropped.
//    flush during SWEEP restarts sweep at 0.
//  Reset values: in_ready 0, rd_valid 0, count 0, full 0, empty 1, buffer_index 0, Instr_in 0.
//  RUN:
//  - pop  = rd_en & !empty. Validator port: buffer_index=rd_ptr, Instr_in=0. mem[rd_ptr]<=0, rd_ptr+1, count-1.
//  - in_ready = !full & !pop (push and pop are mutually exclusive; pop owns validator port).
//  - push = in_valid & in_ready. mem[wr_ptr]<=in_instr; buffer_index=wr_ptr, Instr_in=in_instr (combinational);
//    wr_ptr+1, count+1.
//  - idle cycle: buffer_index=wr_ptr, Instr_in=mem[wr_ptr]. Harmless refresh of the validator bit.
//  - rd_valid=!empty; rd_instr combinational from mem[rd_ptr]; pop latency 0, write-to-read latency 1 cycle.
//  - Pointers wrap bs-1 -> 0 (natural IDX_W overflow).
//  - count never exceeds bs: no push when full. rd_en while empty is ignored, no state change.
//  - Simultaneous push and pop request: pop wins, in_ready=0.
// CONFIGURATION
//  ZERO_FILTER_EN defined:
//    in_valid with in_instr==0 is accepted (in_ready as normal) but not stored.
//    Pointers and count unchanged; validator port shows the idle cycle.
//  ZERO_FILTER_EN undefined:
//    zero words are stored like any other, count increments.
//    Consumer sees rd_valid=1, rd_instr=0; validator bit for that slot stays 0.
// STRUCTURE
//  Package instr_buf_pkg: state enum {SWEEP,RUN}; localparams IDX_W=$clog2(bs), CNT_W=IDX_W+1.
//  Sub-module ib_storage_ram: bs x IWS register array.
//    One write port (addr, data, we) covers push, pop-clear and sweep-clear.
//    Two async read ports: head and wr_ptr refresh.
//  Top level holds FSM, pointers, count and validator-port mux.
// TESTING
//  rst 1 cycle -> in_ready=0, buffer_index 0..15 with Instr_in=0 over 16 cycles, then in_ready=1, empty=1.
//  Push 0xA1,0xA2,0xA3 back-to-back -> count=3.
//    buffer_index 0,1,2 with those words on the push cycles; rd_instr=0xA1.
//  Fill 16 words, hold in_valid -> full=1, in_ready=0.
//    rd_en one cycle -> buffer_index=0, Instr_in=0, count=15; next cycle push lands at slot 0 (wrap).
//  in_valid & rd_en together with count=4 -> pop only, count=3, the offered word is held until the next cycle.
//  flush with count=7 mid-stream -> next cycle SWEEP, count=0, rd_valid=0; 16 cycles later RUN, empty=1.
//  Push 0x0 -> with ZERO_FILTER_EN count unchanged; without it count+1, rd_valid=1, rd_instr=0.

Source files
------------

// File: rtl/instr_buf_pkg.sv
// Shared types and default sizing for the instruction fill buffer.
package instr_buf_pkg;
  localparam int IWS   = 32;
  localparam int BS    = 16;
  localparam int IDX_W = $clog2(BS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/ib_storage_ram.sv
// bs x IWS register array: one write port, two asynchronous read ports.
module ib_storage_ram #(
  parameter int IWS   = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [IWS-1:0] wdata,
  input  logic [AW-1:0]  raddr_a,
  output logic [IWS-1:0] rdata_a,
  input  logic [AW-1:0]  raddr_b,
  output logic [IWS-1:0] rdata_b
);
  logic [DEPTH-1:0][IWS-1:0] mem;

  // No reset on the array; the sweep after reset clears every slot.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/instr_buffer_fill_ctrl.sv
// Circular instruction buffer with slot-clear sweep and validator port mux.
// Optional ZERO_FILTER_EN: accept but do not store all-zero words.
module instr_buffer_fill_ctrl
  import instr_buf_pkg::*;
#(
  parameter int Instruction_word_size = IWS,
  parameter int bs                    = BS,
  localparam int AW = $clog2(bs),
  localparam int CW = AW + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [Instruction_word_size-1:0] in_instr,
  output logic                             in_ready,
  input  logic                             rd_en,
  output logic [Instruction_word_size-1:0] rd_instr,
  output logic                             rd_valid,
  input  logic                             flush,
  output logic [AW-1:0]                    buffer_index,
  output logic [Instruction_word_size-1:0] Instr_in,
  output logic [CW-1:0]                    count,
  output logic                             full,
  output logic                             empty
);
  state_t                           state;
  logic [AW-1:0]                    wr_ptr, rd_ptr, sweep_cnt;
  logic [CW-1:0]                    cnt;
  logic                             run, clr, pop, push;
  logic                             we;
  logic [AW-1:0]                    waddr;
  logic [Instruction_word_size-1:0] wdata, refresh_word;

  assign run   = (state == RUN);
  assign clr   = rst | flush;
  assign full  = (cnt == CW'(bs));
  assign empty = (cnt == '0);
  assign count = cnt;

  // Pop owns the write/validator port, so a pending push waits a cycle.
  assign pop      = run & ~clr & rd_en & ~empty;
  assign in_ready = run & ~clr & ~full & ~pop;
  assign rd_valid = run & ~empty;
`ifdef ZERO_FILTER_EN
  assign push = in_valid & in_ready & (|in_instr);
`else
  assign push = in_valid & in_ready;
`endif

  always_comb begin
    we           = 1'b0;
    waddr        = wr_ptr;
    wdata        = in_instr;
    buffer_index = wr_ptr;
    Instr_in     = refresh_word;
    if (!run) begin
      we           = ~clr;
      waddr        = sweep_cnt;
      wdata        = '0;
      buffer_index = sweep_cnt;
      Instr_in     = '0;
    end else if (pop) begin
      we           = 1'b1;
      waddr        = rd_ptr;
      wdata        = '0;
      buffer_index = rd_ptr;
      Instr_in     = '0;
    end else if (push) begin
      we           = 1'b1;
      Instr_in     = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= SWEEP;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      sweep_cnt <= '0;
    end else if (!run) begin
      sweep_cnt <= sweep_cnt + AW'(1);
      if (sweep_cnt == AW'(bs - 1)) state <= RUN;
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt - CW'(1);
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      cnt    <= cnt + CW'(1);
    end
  end

  ib_storage_ram #(.IWS(Instruction_word_size), .DEPTH(bs)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rd_ptr),
    .rdata_a (rd_instr),
    .raddr_b (wr_ptr),
    .rdata_b (refresh_word)
  );
endmodule
